// File: rtl/alarm_sequencer.sv
// Alarm state controller: compares time against the alarm setting and
// sequences arming, ringing, snooze countdown, ring timeout and dismissal.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | alarm disarmed, buzzer off
// ARMED    | waiting for a time==alarm rising edge
// RINGING  | buzzer on, counting seconds toward ring timeout
// SNOOZE   | buzzer off, counting down snooze seconds
module alarm_sequencer #(
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [4:0] time_hours,
  input  logic [5:0] time_minutes,
  input  logic [4:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       arm_toggle,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       buzzer_en,
  output logic       beep,
  output logic       armed,
  output logic       snoozing,
  output logic [2:0] snooze_used,
  output logic [9:0] snooze_secs
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_MIN * 60);
  localparam logic [2:0] MAX_USED  = 3'(MAX_SNOOZES);

  state_t     state, state_next;
  logic       match, match_prev, trigger;
  logic [7:0] ring_cnt, ring_cnt_next;
  logic [9:0] snz_cnt, snz_cnt_next;
  logic [2:0] used_q, used_next;
  logic       phase, phase_next;
  logic       snooze_ok;

  assign match     = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
  assign trigger   = match && !match_prev;
  assign snooze_ok = used_q < MAX_USED;

  // Register state, counters and the match history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      match_prev <= 1'b0;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      used_q     <= '0;
      phase      <= 1'b1;
    end else begin
      state      <= state_next;
      match_prev <= match;
      ring_cnt   <= ring_cnt_next;
      snz_cnt    <= snz_cnt_next;
      used_q     <= used_next;
      phase      <= phase_next;
    end
  end

  // Next-state selection in priority order, then per-state entry actions.
  always_comb begin
    state_next    = state;
    ring_cnt_next = ring_cnt;
    snz_cnt_next  = snz_cnt;
    used_next     = used_q;
    phase_next    = phase;

    case (state)
      S_IDLE: begin
        if (arm_toggle) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (arm_toggle)   state_next = S_IDLE;
        else if (trigger) state_next = S_RINGING;
      end
      S_RINGING: begin
        if (arm_toggle)                  state_next = S_IDLE;
        else if (dismiss)                state_next = S_ARMED;
        else if (snooze && snooze_ok)    state_next = S_SNOOZE;
        else if (sec_tick) begin
          if (ring_cnt == RING_LAST) begin
            state_next = snooze_ok ? S_SNOOZE : S_ARMED;
          end else begin
            ring_cnt_next = ring_cnt + 8'd1;
            phase_next    = !phase;
          end
        end
      end
      S_SNOOZE: begin
        if (arm_toggle)   state_next = S_IDLE;
        else if (dismiss) state_next = S_ARMED;
        else if (sec_tick) begin
          if (snz_cnt == 10'd1) state_next = S_RINGING;
          else                  snz_cnt_next = snz_cnt - 10'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Entry actions; a sec_tick in the entry cycle is overridden here.
    if (state_next != state) begin
      case (state_next)
        S_RINGING: begin
          ring_cnt_next = '0;
          phase_next    = 1'b1;
        end
        S_SNOOZE: begin
          snz_cnt_next = SNZ_LOAD;
          used_next    = used_q + 3'd1;
        end
        default: begin
          snz_cnt_next = '0;
          used_next    = '0;
        end
      endcase
    end
  end

  assign buzzer_en   = (state == S_RINGING);
  assign beep        = (state == S_RINGING) && phase;
  assign armed       = (state != S_IDLE);
  assign snoozing    = (state == S_SNOOZE);
  assign snooze_used = used_q;
  assign snooze_secs = (state == S_SNOOZE) ? snz_cnt : '0;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Self-checking bench for alarm_sequencer: behavioural model compared every
// cycle, plus hand-computed literal checks along a directed scenario.
module tb_alarm_sequencer;

  localparam int SNZ_MIN = 1;
  localparam int TMO     = 5;
  localparam int MAXS    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic [4:0] time_hours = 5'd7;
  logic [5:0] time_minutes = 6'd29;
  logic [4:0] alarm_hours = 5'd7;
  logic [5:0] alarm_minutes = 6'd30;
  logic       arm_toggle = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       buzzer_en, beep, armed, snoozing;
  logic [2:0] snooze_used;
  logic [9:0] snooze_secs;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  alarm_sequencer #(
    .SNOOZE_MIN(SNZ_MIN),
    .RING_TIMEOUT_S(TMO),
    .MAX_SNOOZES(MAXS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sec_tick(sec_tick),
    .time_hours(time_hours),
    .time_minutes(time_minutes),
    .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes),
    .arm_toggle(arm_toggle),
    .snooze(snooze),
    .dismiss(dismiss),
    .buzzer_en(buzzer_en),
    .beep(beep),
    .armed(armed),
    .snoozing(snoozing),
    .snooze_used(snooze_used),
    .snooze_secs(snooze_secs)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;
  int m_mode = M_IDLE;
  int m_ring_secs = 0;
  int m_snz_left = 0;
  int m_used = 0;
  bit m_prev = 1'b0;

  task m_rest(input int md);
    m_mode = md;
    m_used = 0;
    m_snz_left = 0;
  endtask

  task m_ring();
    m_mode = M_RING;
    m_ring_secs = 0;
  endtask

  task m_snooze();
    m_mode = M_SNZ;
    m_used = m_used + 1;
    m_snz_left = SNZ_MIN * 60;
  endtask

  always @(posedge clk) begin
    bit hit, rising;
    hit = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
    rising = hit && !m_prev;
    if (reset) begin
      m_prev = 1'b0;
      m_rest(M_IDLE);
      m_ring_secs = 0;
    end else begin
      m_prev = hit;
      case (m_mode)
        M_IDLE: if (arm_toggle) m_rest(M_ARMED);
        M_ARMED: begin
          if (arm_toggle) m_rest(M_IDLE);
          else if (rising) m_ring();
        end
        M_RING: begin
          if (arm_toggle) m_rest(M_IDLE);
          else if (dismiss) m_rest(M_ARMED);
          else if (snooze && m_used < MAXS) m_snooze();
          else if (sec_tick) begin
            m_ring_secs = m_ring_secs + 1;
            if (m_ring_secs == TMO) begin
              if (m_used < MAXS) m_snooze();
              else m_rest(M_ARMED);
            end
          end
        end
        default: begin
          if (arm_toggle) m_rest(M_IDLE);
          else if (dismiss) m_rest(M_ARMED);
          else if (sec_tick) begin
            m_snz_left = m_snz_left - 1;
            if (m_snz_left == 0) m_ring();
          end
        end
      endcase
    end
  end

  task cmp(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("m_buzzer_en", int'(buzzer_en), (m_mode == M_RING) ? 1 : 0);
      cmp("m_beep", int'(beep), (m_mode == M_RING && (m_ring_secs % 2) == 0) ? 1 : 0);
      cmp("m_armed", int'(armed), (m_mode != M_IDLE) ? 1 : 0);
      cmp("m_snoozing", int'(snoozing), (m_mode == M_SNZ) ? 1 : 0);
      cmp("m_snooze_used", int'(snooze_used), m_used);
      cmp("m_snooze_secs", int'(snooze_secs), (m_mode == M_SNZ) ? m_snz_left : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      arm_toggle = 1'b0;
      snooze = 1'b0;
      dismiss = 1'b0;
      sec_tick = 1'b0;
    end
  endtask

  task secs(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      cyc(1);
      cyc(1);
    end
  endtask

  task set_time(input int h, input int m);
    time_hours = 5'(h);
    time_minutes = 6'(m);
  endtask

  // New match edge at 07:30: leave the minute, come back.
  task ring_again();
    set_time(7, 31);
    cyc(2);
    set_time(7, 30);
    cyc(1);
  endtask

  initial begin
    cyc(2);
    chk_on = 1'b1;
    reset = 1'b0;
    cmp("rst_buzzer", int'(buzzer_en), 0);
    cmp("rst_armed", int'(armed), 0);
    cmp("rst_used", int'(snooze_used), 0);
    cmp("rst_secs", int'(snooze_secs), 0);

    // Arm, then 07:29 -> 07:30 rings one cycle later.
    arm_toggle = 1'b1; cyc(1);
    cmp("arm_armed", int'(armed), 1);
    set_time(7, 30);
    cyc(1);
    cmp("trig_buzzer", int'(buzzer_en), 1);
    cmp("trig_beep", int'(beep), 1);
    secs(1);
    cmp("beep_off", int'(beep), 0);
    secs(1);
    cmp("beep_on", int'(beep), 1);
    dismiss = 1'b1; cyc(1);
    cmp("dismiss_buzzer", int'(buzzer_en), 0);
    cmp("dismiss_armed", int'(armed), 1);
    cyc(6);
    cmp("no_rering", int'(buzzer_en), 0);

    // Manual snooze and expiry.
    ring_again();
    cmp("ring2_buzzer", int'(buzzer_en), 1);
    snooze = 1'b1; cyc(1);
    cmp("snz_snoozing", int'(snoozing), 1);
    cmp("snz_used", int'(snooze_used), 1);
    cmp("snz_secs60", int'(snooze_secs), 60);
    secs(1);
    cmp("snz_secs59", int'(snooze_secs), 59);
    secs(58);
    cmp("snz_secs1", int'(snooze_secs), 1);
    cmp("snz_still", int'(buzzer_en), 0);
    secs(1);
    cmp("snz_expire", int'(buzzer_en), 1);
    cmp("snz_expire_used", int'(snooze_used), 1);

    // Auto-snooze on timeout, snooze refused at max, final timeout.
    secs(4);
    cmp("tmo_pending", int'(buzzer_en), 1);
    secs(1);
    cmp("tmo_snoozing", int'(snoozing), 1);
    cmp("tmo_used2", int'(snooze_used), 2);
    secs(60);
    cmp("tmo_ring3", int'(buzzer_en), 1);
    snooze = 1'b1; cyc(1);
    cmp("max_snz_ignored", int'(buzzer_en), 1);
    cmp("max_snz_nosnooze", int'(snoozing), 0);
    secs(5);
    cmp("final_tmo_buzzer", int'(buzzer_en), 0);
    cmp("final_tmo_armed", int'(armed), 1);
    cmp("final_tmo_used", int'(snooze_used), 0);

    // dismiss + snooze together -> ARMED.
    ring_again();
    dismiss = 1'b1; snooze = 1'b1; cyc(1);
    cmp("dis_snz_armed", int'(armed), 1);
    cmp("dis_snz_buzzer", int'(buzzer_en), 0);
    cmp("dis_snz_snoozing", int'(snoozing), 0);

    // Re-arm inside the matching minute: no ring.
    arm_toggle = 1'b1; cyc(1);
    cmp("disarm", int'(armed), 0);
    arm_toggle = 1'b1; cyc(1);
    cyc(3);
    cmp("arm_in_match_armed", int'(armed), 1);
    cmp("arm_in_match_quiet", int'(buzzer_en), 0);

    // Reset while ringing.
    ring_again();
    cmp("pre_reset_ring", int'(buzzer_en), 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    cmp("reset_buzzer", int'(buzzer_en), 0);
    cmp("reset_beep", int'(beep), 0);
    cmp("reset_armed", int'(armed), 0);

    // Disarmed at a match edge.
    ring_again();
    cyc(1);
    cmp("idle_match_quiet", int'(buzzer_en), 0);

    // Midnight wrap, trigger coinciding with sec_tick.
    alarm_hours = 5'd0; alarm_minutes = 6'd0;
    set_time(23, 59);
    arm_toggle = 1'b1; cyc(1);
    cyc(2);
    set_time(0, 0);
    sec_tick = 1'b1; cyc(1);
    cmp("midnight_ring", int'(buzzer_en), 1);
    cmp("midnight_beep", int'(beep), 1);

    // Snooze with coincident sec_tick loads a full count; snooze in SNOOZE ignored.
    snooze = 1'b1; sec_tick = 1'b1; cyc(1);
    cmp("entry_tick_secs", int'(snooze_secs), 60);
    snooze = 1'b1; cyc(1);
    cmp("snz_in_snz_used", int'(snooze_used), 1);
    secs(3);
    cmp("snz_secs57", int'(snooze_secs), 57);
    arm_toggle = 1'b1; dismiss = 1'b1; cyc(1);
    cmp("arm_over_dismiss", int'(armed), 0);
    cmp("arm_clears_used", int'(snooze_used), 0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
